// File: rtl/reverb_wet_dry_mixer_if.sv
// Sample-strobe, reverb FIFO read side, mixed output and debug counters
// of the reverb wet/dry mixer, bundled so one connection carries the whole bus.
interface reverb_wet_dry_mixer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic                     Dry_Valid;
  logic signed [DATA_W-1:0] Dry_Data;
  logic                     Wet_Empty;
  logic                     Wet_Read_En;
  logic signed [DATA_W-1:0] Wet_Data;
  logic        [3:0]        Mix_Level;
  logic                     Out_Valid;
  logic signed [DATA_W-1:0] Out_Data;
  logic        [CNT_W-1:0]  Underrun_Cnt;
  logic        [CNT_W-1:0]  Drop_Cnt;

  modport master (
    output Dry_Valid, Dry_Data, Wet_Empty, Wet_Data, Mix_Level,
    input  Wet_Read_En, Out_Valid, Out_Data, Underrun_Cnt, Drop_Cnt
  );

  modport slave (
    input  Dry_Valid, Dry_Data, Wet_Empty, Wet_Data, Mix_Level,
    output Wet_Read_En, Out_Valid, Out_Data, Underrun_Cnt, Drop_Cnt
  );
endinterface

// File: rtl/reverb_wet_dry_mixer.sv
// Mixes one reverb FIFO sample into each dry sample at a 1/16-step wet level,
// with signed saturation, fixed 4-cycle latency and underrun/drop debug counters.
module reverb_wet_dry_mixer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic                   Clk,
  input logic                   rst,
  reverb_wet_dry_mixer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MIX,
    S_OUT
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic signed [DATA_W-1:0] r_dry;
  logic signed [DATA_W-1:0] r_wet;
  logic        [3:0]        r_level;
  logic                     r_wet_ok;
  logic signed [DATA_W+1:0] r_sum;
  logic        [CNT_W-1:0]  r_under;
  logic        [CNT_W-1:0]  r_drop;
  logic                     w_rd_en;
  logic                     w_out_vld;
  logic signed [DATA_W+4:0] w_wet_x;
  logic signed [DATA_W+4:0] w_lvl_x;
  logic signed [DATA_W+4:0] w_prod;
  logic signed [DATA_W+1:0] w_prod_sh;
  logic signed [DATA_W+1:0] w_sum;

  function automatic logic signed [DATA_W-1:0] sat_sum(input logic signed [DATA_W+1:0] v);
    // In range exactly when the top three bits agree.
    if ((v[DATA_W+1:DATA_W-1] == 3'b000) || (v[DATA_W+1:DATA_W-1] == 3'b111))
      return v[DATA_W-1:0];
    else if (v[DATA_W+1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_out_vld = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.Dry_Valid) w_next = S_FETCH;
      S_FETCH: begin
        w_rd_en = !bus.Wet_Empty;
        w_next  = S_WAIT;
      end
      S_WAIT:  w_next = S_MIX;
      S_MIX:   w_next = S_OUT;
      S_OUT: begin
        w_out_vld = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Wet gain: level is zero-extended so 15 stays +15, then >>>4 floors toward -inf.
  assign w_wet_x   = {{5{r_wet[DATA_W-1]}}, r_wet};
  assign w_lvl_x   = {{DATA_W{1'b0}}, 1'b0, r_level};
  assign w_prod    = w_wet_x * w_lvl_x;
  assign w_prod_sh = (DATA_W+2)'(w_prod >>> 4);
  assign w_sum     = {{2{r_dry[DATA_W-1]}}, r_dry} + w_prod_sh;

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_dry    <= '0;
      r_level  <= '0;
      r_wet_ok <= 1'b0;
      r_wet    <= '0;
      r_sum    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.Dry_Valid) begin
          r_dry   <= bus.Dry_Data;
          r_level <= bus.Mix_Level;
        end
        S_FETCH: r_wet_ok <= !bus.Wet_Empty;
        S_WAIT:  r_wet    <= r_wet_ok ? bus.Wet_Data : '0;
        S_MIX:   r_sum    <= w_sum;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_under <= '0;
      r_drop  <= '0;
    end else begin
      if ((r_state == S_WAIT) && !r_wet_ok)
        r_under <= sat_inc(r_under);
      if (bus.Dry_Valid && (r_state != S_IDLE))
        r_drop <= sat_inc(r_drop);
    end
  end

  assign bus.Wet_Read_En  = w_rd_en;
  assign bus.Out_Valid    = w_out_vld;
  assign bus.Out_Data     = sat_sum(r_sum);
  assign bus.Underrun_Cnt = r_under;
  assign bus.Drop_Cnt     = r_drop;

endmodule

// File: tb/tb_reverb_wet_dry_mixer.sv
// Directed plus randomized bench for the reverb wet/dry mixer with a
// one-clock-latency FIFO model and an integer-arithmetic reference.
module tb_reverb_wet_dry_mixer;

  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  reverb_wet_dry_mixer_if #(.DATA_W(16), .CNT_W(16)) bus ();

  reverb_wet_dry_mixer #(.DATA_W(16), .CNT_W(16)) dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk;
  int          n_err;
  int          exp_under;
  int          exp_drop;
  int          n_push;
  int          rd_count = 0;
  int          bad_rd   = 0;
  logic [15:0] fifo_mem [0:255];

  // FIFO model: Q valid the cycle after RdEn, garbage otherwise.
  assign bus.Wet_Empty = (n_push == rd_count);
  always @(posedge Clk) begin
    if (bus.Wet_Read_En) begin
      if (n_push == rd_count) bad_rd <= bad_rd + 1;
      bus.Wet_Data <= fifo_mem[rd_count[7:0]];
      rd_count     <= rd_count + 1;
    end else begin
      bus.Wet_Data <= 16'($urandom);
    end
  end

  function automatic logic [15:0] model(input logic [15:0] dry, input logic [15:0] wet,
                                        input logic [3:0] lvl, input bit has_wet);
    int d, w, p, q, s;
    d = int'($signed(dry));
    w = has_wet ? int'($signed(wet)) : 0;
    p = w * int'(lvl);
    q = p / 16;
    if ((p < 0) && ((p % 16) != 0)) q = q - 1;
    s = d + q;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[n_push[7:0]] = w;
    n_push++;
  endtask

  // Entered at posedge+1 with the DUT idle; leaves it idle 8 cycles later.
  task automatic run_sample(input logic [15:0] dry, input logic [3:0] lvl,
                            input bit has_wet, input logic [15:0] wet);
    int          lat, pulses, rd0;
    logic [15:0] got, exp;
    logic        rd_at1;
    exp = model(dry, wet, lvl, has_wet);
    if (has_wet) push(wet);
    rd0 = rd_count; lat = -1; pulses = 0; got = '0; rd_at1 = 1'b0;
    bus.Dry_Valid = 1'b1;
    bus.Dry_Data  = dry;
    bus.Mix_Level = lvl;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      bus.Dry_Valid = 1'b0;
      bus.Dry_Data  = 16'($urandom);
      bus.Mix_Level = 4'($urandom);
      if (k == 1) rd_at1 = bus.Wet_Read_En;
      if (bus.Out_Valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = bus.Out_Data;
        end
      end
    end
    if (!has_wet) exp_under++;
    chk("rd_en_T1",  16'(rd_at1), 16'(has_wet));
    chk("latency",   16'(lat), 16'd4);
    chk("out_data",  got, exp);
    chk("one_pulse", 16'(pulses), 16'd1);
    chk("hold",      bus.Out_Data, exp);
    chk("pops",      16'(rd_count - rd0), 16'(has_wet));
    chk("underrun",  bus.Underrun_Cnt, 16'(exp_under));
    chk("drop",      bus.Drop_Cnt, 16'(exp_drop));
  endtask

  // mask[k-1] raises Dry_Valid at T+k; all of those must be dropped.
  task automatic run_overlap(input logic [3:0] mask);
    logic [15:0] dry, wet, exp;
    logic [3:0]  lvl;
    dry = 16'($urandom); wet = 16'($urandom); lvl = 4'($urandom);
    exp = model(dry, wet, lvl, 1'b1);
    push(wet);
    bus.Dry_Valid = 1'b1;
    bus.Dry_Data  = dry;
    bus.Mix_Level = lvl;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk); #1;
      bus.Dry_Valid = mask[k-1];
      bus.Dry_Data  = 16'($urandom);
      bus.Mix_Level = 4'($urandom);
      if (k == 4) begin
        chk("ovl_vld_T4",  16'(bus.Out_Valid), 16'd1);
        chk("ovl_data_T4", bus.Out_Data, exp);
      end
    end
    @(posedge Clk); #1;
    bus.Dry_Valid = 1'b0;
    exp_drop += $countones(mask);
    chk("ovl_vld_T5", 16'(bus.Out_Valid), 16'd0);
    chk("ovl_drop",   bus.Drop_Cnt, 16'(exp_drop));
  endtask

  initial begin
    int pulses;
    n_chk = 0; n_err = 0; exp_under = 0; exp_drop = 0; n_push = 0;
    bus.Dry_Valid = 1'b0;
    bus.Dry_Data  = '0;
    bus.Mix_Level = '0;
    rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out_vld", 16'(bus.Out_Valid), 16'd0);
    chk("rst_out_dat", bus.Out_Data, 16'h0000);
    chk("rst_under",   bus.Underrun_Cnt, 16'd0);
    chk("rst_drop",    bus.Drop_Cnt, 16'd0);
    chk("rst_rd_en",   16'(bus.Wet_Read_En), 16'd0);
    rst = 1'b0;
    @(posedge Clk); #1;

    run_sample(16'h1000, 4'd8,  1'b1, 16'h0800);
    run_sample(16'h8000, 4'd0,  1'b1, 16'h7FFF);
    run_sample(16'h7000, 4'd15, 1'b1, 16'h7FFF);
    run_sample(16'h9000, 4'd15, 1'b1, 16'h8000);
    run_sample(16'h0123, 4'd15, 1'b0, 16'h0000);

    run_overlap(4'b0010);
    run_sample(16'($urandom), 4'($urandom), 1'b1, 16'($urandom));
    run_overlap(4'b1111);
    run_sample(16'($urandom), 4'($urandom), 1'b1, 16'($urandom));

    for (int i = 0; i < 20; i++)
      run_sample(16'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom));

    // Abandon a sample with reset during its WAIT cycle.
    push(16'($urandom));
    bus.Dry_Valid = 1'b1;
    bus.Dry_Data  = 16'h4321;
    bus.Mix_Level = 4'd7;
    @(posedge Clk); #1;
    bus.Dry_Valid = 1'b0;
    @(posedge Clk); #1;
    rst = 1'b1;
    @(posedge Clk); #1;
    chk("mrst_out_vld", 16'(bus.Out_Valid), 16'd0);
    chk("mrst_out_dat", bus.Out_Data, 16'h0000);
    chk("mrst_under",   bus.Underrun_Cnt, 16'd0);
    chk("mrst_drop",    bus.Drop_Cnt, 16'd0);
    chk("mrst_rd_en",   16'(bus.Wet_Read_En), 16'd0);
    rst = 1'b0;
    exp_under = 0; exp_drop = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      if (bus.Out_Valid) pulses++;
    end
    chk("mrst_no_out", 16'(pulses), 16'd0);
    run_sample(16'($urandom), 4'($urandom), 1'b1, 16'($urandom));
    run_sample(16'h0ABC, 4'd15, 1'b0, 16'h0000);

    chk("no_read_while_empty", 16'(bad_rd), 16'd0);
    chk("fifo_drained", 16'(n_push - rd_count), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
